// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Contents:
//   fwd_sel_t    - Execute operand forwarding select encoding
//   mul_state_t  - mul/div sequencer state, with IDLE/BUSY constants
//   REG_X0       - hard-wired zero register index
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef logic [0:0] mul_state_t;
  localparam mul_state_t IDLE = 1'b0;
  localparam mul_state_t BUSY = 1'b1;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard-unit signals exchanged with the pipeline stage modules.
// master: stage side (drives register indices / status, receives controls)
// slave : pipeline_ctrl side
// Signals: Rs1D/Rs2D/Rs1E/Rs2E/RdE/RdM/RdW, RegWriteM/W, ResultSrcE0, PCSrcE,
//          MulStartE, MulDoneE in; ForwardAE/BE, StallF/D/E, FlushD/E/M,
//          MulBusy, MulTimeout, StallCycles, FlushCount out.
interface pipeline_ctrl_if #(parameter int WIDTH = 32);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
  logic             MulStartE, MulDoneE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic             MulBusy, MulTimeout;
  logic [WIDTH-1:0] StallCycles, FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulStartE, MulDoneE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  MulBusy, MulTimeout, StallCycles, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulStartE, MulDoneE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output MulBusy, MulTimeout, StallCycles, FlushCount
  );
endinterface

// File: rtl/pipeline_ctrl_forward_sel.sv
// Per-operand forwarding select for the Execute stage.
// Inputs : RsE (source reg in E), RdM/RdW (dest regs in M/W), RegWriteM/W.
// Output : Forward - FWD_MEM beats FWD_WB beats FWD_RF; x0 never forwards.
module forward_sel
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output fwd_sel_t   Forward
);

  always_comb begin
    Forward = FWD_RF;
    if (RegWriteM && RdM != REG_X0 && RdM == RsE)
      Forward = FWD_MEM;
    else if (RegWriteW && RdW != REG_X0 && RdW == RsE)
      Forward = FWD_WB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RISC-V pipeline.
// Forwarding selects, load-use stall, branch flush, and a two-state
// sequencer that holds F/D/E while the multi-cycle mul/div unit runs.
// Ports: clk, rst (sync, active-high), bus (pipeline_ctrl_if.slave).
// Optional: PIPE_PERF_CNT_EN enables StallCycles/FlushCount counters;
// otherwise both read as zero.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int MAX_MUL_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_MUL_CYCLES);

  fwd_sel_t   fwd_a, fwd_b;
  mul_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  logic lw_stall, mul_req, mul_stall, stall_f;

  forward_sel u_fwd_a (
    .RsE(bus.Rs1E), .RdM(bus.RdM), .RdW(bus.RdW),
    .RegWriteM(bus.RegWriteM), .RegWriteW(bus.RegWriteW), .Forward(fwd_a)
  );

  forward_sel u_fwd_b (
    .RsE(bus.Rs2E), .RdM(bus.RdM), .RdW(bus.RdW),
    .RegWriteM(bus.RegWriteM), .RegWriteW(bus.RegWriteW), .Forward(fwd_b)
  );

  always_comb begin
    lw_stall = bus.ResultSrcE0 && bus.RdE != REG_X0 &&
               (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
    mul_req  = (state_q == IDLE && bus.MulStartE) ||
               (state_q == BUSY && !bus.MulDoneE);
    // A taken branch must never coincide with a mul stall; if it does,
    // the redirect wins so the pipeline stays coherent.
    mul_stall = mul_req && !bus.PCSrcE;
  end

  // Sequencer and watchdog next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == IDLE) begin
      if (bus.MulStartE && !bus.PCSrcE) begin
        state_d = BUSY;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      // Watchdog only flags; the op keeps waiting for done.
      if (cnt_d == CNT_LIM) timeout_d = 1'b1;
      if (bus.MulDoneE) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // While rst is high the pipeline is held flushed with no stalls, even in
  // the cycle where the registered state has not yet been cleared.
  assign stall_f        = !rst && (mul_stall || lw_stall);
  assign bus.StallF     = stall_f;
  assign bus.StallD     = stall_f;
  assign bus.StallE     = !rst && mul_stall;
  assign bus.FlushM     = rst || mul_stall;
  assign bus.FlushE     = rst || (lw_stall && !mul_stall) || bus.PCSrcE;
  assign bus.FlushD     = rst || bus.PCSrcE;
  assign bus.ForwardAE  = rst ? FWD_RF : fwd_a;
  assign bus.ForwardBE  = rst ? FWD_RF : fwd_b;
  assign bus.MulBusy    = !rst && state_q == BUSY;
  assign bus.MulTimeout = !rst && timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f)    stall_cnt_q <= stall_cnt_q + WIDTH'(1);
      if (bus.PCSrcE) flush_cnt_q <= flush_cnt_q + WIDTH'(1);
    end
  end

  assign bus.StallCycles = stall_cnt_q;
  assign bus.FlushCount  = flush_cnt_q;
`else
  assign bus.StallCycles = {WIDTH{1'b0}};
  assign bus.FlushCount  = {WIDTH{1'b0}};
`endif

`ifndef SYNTHESIS
  // A mul op is never a branch.
  a_no_branch_in_mul: assert property (@(posedge clk) disable iff (rst)
    !(bus.PCSrcE && mul_req));
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int exp_stall = 0;
  int exp_perf;

  pipeline_ctrl_if #(.WIDTH(32)) bus ();

  pipeline_ctrl #(.WIDTH(32), .MAX_MUL_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task clear_in;
    bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0;
    bus.RdE = 0; bus.RdM = 0; bus.RdW = 0;
    bus.RegWriteM = 0; bus.RegWriteW = 0; bus.ResultSrcE0 = 0;
    bus.PCSrcE = 0; bus.MulStartE = 0; bus.MulDoneE = 0;
  endtask

  task next_cycle;
    @(posedge clk); #1;
  endtask

  task test_reset;
    rst = 1; clear_in();
    bus.Rs1E = 5; bus.RdM = 5; bus.RegWriteM = 1; bus.MulStartE = 1;
    next_cycle(); #1;
    checks++; if (bus.ForwardAE !== 2'b00) begin errors++; $display("FAIL reset_fwdA got=%b exp=00", bus.ForwardAE); end
    checks++; if ({bus.StallF, bus.StallD, bus.StallE} !== 3'b000) begin errors++; $display("FAIL reset_stalls got=%b exp=000", {bus.StallF, bus.StallD, bus.StallE}); end
    checks++; if ({bus.FlushD, bus.FlushE, bus.FlushM} !== 3'b111) begin errors++; $display("FAIL reset_flushes got=%b exp=111", {bus.FlushD, bus.FlushE, bus.FlushM}); end
    checks++; if ({bus.MulBusy, bus.MulTimeout} !== 2'b00) begin errors++; $display("FAIL reset_mul got=%b exp=00", {bus.MulBusy, bus.MulTimeout}); end
    next_cycle(); rst = 0; clear_in(); #1;
    checks++; if ({bus.StallF, bus.FlushD, bus.FlushE, bus.FlushM, bus.MulBusy} !== 5'b0) begin errors++; $display("FAIL post_reset_ctrl got=%b exp=00000", {bus.StallF, bus.FlushD, bus.FlushE, bus.FlushM, bus.MulBusy}); end
    checks++; if (bus.StallCycles !== 32'd0 || bus.FlushCount !== 32'd0) begin errors++; $display("FAIL post_reset_perf got=%0d/%0d exp=0/0", bus.StallCycles, bus.FlushCount); end
  endtask

  task test_forward;
    next_cycle();
    bus.Rs1E = 5; bus.Rs2E = 5; bus.RdM = 5; bus.RdW = 5; bus.RegWriteM = 1; bus.RegWriteW = 1; #1;
    checks++; if (bus.ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_mem_prio_A got=%b exp=10", bus.ForwardAE); end
    checks++; if (bus.ForwardBE !== 2'b10) begin errors++; $display("FAIL fwd_mem_prio_B got=%b exp=10", bus.ForwardBE); end
    bus.RegWriteM = 0; #1;
    checks++; if (bus.ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_wb_A got=%b exp=01", bus.ForwardAE); end
    checks++; if (bus.ForwardBE !== 2'b01) begin errors++; $display("FAIL fwd_wb_B got=%b exp=01", bus.ForwardBE); end
    bus.Rs1E = 0; bus.RdM = 0; bus.RdW = 0; bus.RegWriteM = 1; #1;
    checks++; if (bus.ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_x0 got=%b exp=00", bus.ForwardAE); end
    bus.Rs1E = 3; bus.Rs2E = 4; bus.RdM = 4; bus.RdW = 3; #1;
    checks++; if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0110) begin errors++; $display("FAIL fwd_mixed got=%b exp=0110", {bus.ForwardAE, bus.ForwardBE}); end
    clear_in();
  endtask

  task test_load_use;
    next_cycle();
    bus.ResultSrcE0 = 1; bus.RdE = 7; bus.Rs1D = 3; bus.Rs2D = 7; #1;
    checks++; if ({bus.StallF, bus.StallD, bus.FlushE, bus.StallE, bus.FlushM, bus.FlushD} !== 6'b111000) begin errors++; $display("FAIL lw_stall got=%b exp=111000", {bus.StallF, bus.StallD, bus.FlushE, bus.StallE, bus.FlushM, bus.FlushD}); end
    exp_stall++;
    next_cycle();
    bus.ResultSrcE0 = 0; bus.RdE = 0; #1;
    checks++; if ({bus.StallF, bus.StallD, bus.FlushE} !== 3'b000) begin errors++; $display("FAIL lw_one_cycle got=%b exp=000", {bus.StallF, bus.StallD, bus.FlushE}); end
    bus.ResultSrcE0 = 1; bus.RdE = 0; bus.Rs1D = 0; #1;
    checks++; if ({bus.StallF, bus.FlushE} !== 2'b00) begin errors++; $display("FAIL lw_x0 got=%b exp=00", {bus.StallF, bus.FlushE}); end
    clear_in();
  endtask

  task test_branch;
    next_cycle();
    bus.PCSrcE = 1; #1;
    checks++; if ({bus.FlushD, bus.FlushE, bus.FlushM, bus.StallF, bus.StallD, bus.StallE} !== 6'b110000) begin errors++; $display("FAIL branch_ctrl got=%b exp=110000", {bus.FlushD, bus.FlushE, bus.FlushM, bus.StallF, bus.StallD, bus.StallE}); end
    next_cycle();
    bus.PCSrcE = 0; #1;
    checks++; if ({bus.MulBusy, bus.FlushD, bus.FlushE} !== 3'b000) begin errors++; $display("FAIL branch_after got=%b exp=000", {bus.MulBusy, bus.FlushD, bus.FlushE}); end
`ifdef PIPE_PERF_CNT_EN
    exp_perf = 1;
`else
    exp_perf = 0;
`endif
    checks++; if (bus.FlushCount !== 32'(exp_perf)) begin errors++; $display("FAIL branch_flushcount got=%0d exp=%0d", bus.FlushCount, exp_perf); end
  endtask

  task test_mul;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      bus.MulStartE = 1; bus.MulDoneE = (c == 4); #1;
      checks++; if ({bus.StallF, bus.StallD, bus.StallE, bus.FlushM} !== {4{c < 4}}) begin errors++; $display("FAIL mul_stall c%0d got=%b exp=%b", c, {bus.StallF, bus.StallD, bus.StallE, bus.FlushM}, {4{c < 4}}); end
      checks++; if (bus.MulBusy !== (c >= 2)) begin errors++; $display("FAIL mul_busy c%0d got=%b exp=%b", c, bus.MulBusy, c >= 2); end
    end
    exp_stall += 3;
    next_cycle();
    bus.MulStartE = 0; bus.MulDoneE = 0; #1;
    checks++; if ({bus.MulBusy, bus.StallF, bus.FlushM} !== 3'b000) begin errors++; $display("FAIL mul_end got=%b exp=000", {bus.MulBusy, bus.StallF, bus.FlushM}); end
`ifdef PIPE_PERF_CNT_EN
    exp_perf = exp_stall;
`else
    exp_perf = 0;
`endif
    checks++; if (bus.StallCycles !== 32'(exp_perf)) begin errors++; $display("FAIL mul_stallcycles got=%0d exp=%0d", bus.StallCycles, exp_perf); end
  endtask

  task test_back_to_back;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      bus.MulStartE = 1; bus.MulDoneE = (c == 2 || c == 4); #1;
      checks++; if ({bus.StallE, bus.MulBusy} !== ((c % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b c%0d got=%b exp=%b", c, {bus.StallE, bus.MulBusy}, (c % 2) ? 2'b10 : 2'b01); end
    end
    exp_stall += 2;
    next_cycle();
    bus.MulStartE = 0; bus.MulDoneE = 1; #1;
    next_cycle();
    bus.MulDoneE = 0; #1;
    checks++; if ({bus.MulBusy, bus.StallE} !== 2'b00) begin errors++; $display("FAIL done_in_idle got=%b exp=00", {bus.MulBusy, bus.StallE}); end
  endtask

  task test_mul_lw;
    next_cycle();
    bus.MulStartE = 1; #1;
    next_cycle();
    bus.ResultSrcE0 = 1; bus.RdE = 9; bus.Rs1D = 9; #1;
    checks++; if ({bus.MulBusy, bus.StallF, bus.StallE, bus.FlushE} !== 4'b1110) begin errors++; $display("FAIL mul_lw got=%b exp=1110", {bus.MulBusy, bus.StallF, bus.StallE, bus.FlushE}); end
    next_cycle();
    rst = 1; #1;
    checks++; if ({bus.StallF, bus.StallE, bus.FlushD, bus.FlushE, bus.FlushM, bus.MulBusy} !== 6'b001110) begin errors++; $display("FAIL rst_mid_busy got=%b exp=001110", {bus.StallF, bus.StallE, bus.FlushD, bus.FlushE, bus.FlushM, bus.MulBusy}); end
    next_cycle();
    rst = 0; clear_in(); #1;
    exp_stall = 0;
    checks++; if ({bus.MulBusy, bus.StallF, bus.StallD, bus.StallE} !== 4'b0000) begin errors++; $display("FAIL after_rst_idle got=%b exp=0000", {bus.MulBusy, bus.StallF, bus.StallD, bus.StallE}); end
    checks++; if (bus.StallCycles !== 32'd0) begin errors++; $display("FAIL after_rst_perf got=%0d exp=0", bus.StallCycles); end
  endtask

  task test_watchdog;
    next_cycle();
    bus.MulStartE = 1; #1;
    exp_stall++;
    for (int k = 1; k <= 11; k++) begin
      next_cycle(); #1;
      exp_stall++;
      checks++; if (bus.MulTimeout !== (k >= 9)) begin errors++; $display("FAIL watchdog k%0d got=%b exp=%b", k, bus.MulTimeout, k >= 9); end
    end
    next_cycle();
    bus.MulDoneE = 1; #1;
    checks++; if ({bus.StallF, bus.MulBusy, bus.MulTimeout} !== 3'b011) begin errors++; $display("FAIL watchdog_done got=%b exp=011", {bus.StallF, bus.MulBusy, bus.MulTimeout}); end
`ifdef PIPE_PERF_CNT_EN
    exp_perf = exp_stall;
`else
    exp_perf = 0;
`endif
    checks++; if (bus.StallCycles !== 32'(exp_perf)) begin errors++; $display("FAIL watchdog_stallcycles got=%0d exp=%0d", bus.StallCycles, exp_perf); end
    next_cycle();
    bus.MulStartE = 0; bus.MulDoneE = 0; #1;
    checks++; if ({bus.MulBusy, bus.MulTimeout} !== 2'b01) begin errors++; $display("FAIL timeout_sticky got=%b exp=01", {bus.MulBusy, bus.MulTimeout}); end
    next_cycle();
    rst = 1; #1;
    next_cycle();
    rst = 0; #1;
    checks++; if (bus.MulTimeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b exp=0", bus.MulTimeout); end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mul();
    test_back_to_back();
    test_mul_lw();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
